// File: rtl/alu_if.sv
// ---------------------------------------------------------------------------
// alu_if
// Operand/result bundle between the CPU datapath and the sequential ALU.
//
// Parameters
//   WIDTH      operand/result width in bits
//
// Signals
//   in_valid   operands/op valid this cycle              (master -> slave)
//   in_ready   ALU can accept; transfer = valid & ready   (slave -> master)
//   op         3-bit operation code                       (master -> slave)
//   a, b       operands                                   (master -> slave)
//   cin_en     chain ADD/SUB with the current C flag      (master -> slave)
//   flags_we   write this op's flags into the register    (master -> slave)
//   result     registered result, held between completions(slave -> master)
//   out_valid  one-cycle completion pulse                 (slave -> master)
//   flags      registered {Z,C,N,V}                       (slave -> master)
//
// Modports
//   master     the datapath side that issues operations
//   slave      the ALU
// ---------------------------------------------------------------------------
interface alu_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin_en;
  logic             flags_we;
  logic [WIDTH-1:0] result;
  logic             out_valid;
  logic [3:0]       flags;

  modport master (
    output in_valid, op, a, b, cin_en, flags_we,
    input  in_ready, result, out_valid, flags
  );

  modport slave (
    input  in_valid, op, a, b, cin_en, flags_we,
    output in_ready, result, out_valid, flags
  );
endinterface

// File: rtl/alu_seq.sv
// ---------------------------------------------------------------------------
// alu_seq
// Registered ALU for the CPU datapath. Single-cycle add/sub (with carry
// chaining through the C flag), AND/OR/XOR, one-bit logical shifts, and an
// optional shift-add multiplier that occupies WIDTH cycles. Keeps a persistent
// {Z,C,N,V} flags register used by conditional jumps.
//
// Build option
//   ALU_MUL_EN  defined   : op 111 is an unsigned multiply (low WIDTH bits of
//                           a*b, C = high half non-zero), BUSY for WIDTH cycles,
//                           in_ready low while busy.
//               undefined : no multiplier and no BUSY state; op 111 completes
//                           in one cycle with result 0 and flags untouched;
//                           in_ready is tied high.
//
// Parameters
//   WIDTH      operand/result width in bits (>= 4)
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset (aborts a multiply in flight)
//   bus        alu_if.slave: in_valid/in_ready handshake, op, a, b, cin_en,
//              flags_we, result, out_valid, flags
//
// Op codes: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL, 110 SHR,
//           111 MUL. Flags are packed {Z,C,N,V} (bit 3 .. bit 0).
// ---------------------------------------------------------------------------
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic  clk,
  input  logic  rst_n,
  alu_if.slave  bus
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  // Flags are packed {Z,C,N,V}; C lives at bit 2.
  localparam int FLAG_C = 2;

  // Z and N always follow the result; C and V are op specific.
  function automatic logic [3:0] pack_flags(input logic [WIDTH-1:0] r,
                                            input logic             c,
                                            input logic             v);
    pack_flags = {(r == '0), c, r[WIDTH-1], v};
  endfunction

  logic [WIDTH-1:0] res_p1;
  logic [3:0]       flg_p1;
  logic             vld_p1;
  logic             xfer;

  logic [WIDTH-1:0] b_eff;
  logic             cin_c;
  logic [WIDTH:0]   sum_c;
  logic [WIDTH-1:0] res_c;
  logic             c_c;
  logic             v_c;
  logic [3:0]       flg_c;

  // Stage p0: single-cycle ALU evaluated on the operands presented this cycle.
  always_comb begin
    b_eff = (bus.op == OP_SUB) ? ~bus.b : bus.b;
    // SUB without chaining injects 1 to form the two's complement; with
    // chaining the stored C acts as "no borrow".
    if (bus.cin_en) cin_c = flg_p1[FLAG_C];
    else            cin_c = (bus.op == OP_SUB);
    sum_c = {1'b0, bus.a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin_c};
    res_c = '0;
    c_c   = 1'b0;
    v_c   = 1'b0;
    case (bus.op)
      OP_ADD, OP_SUB: begin
        res_c = sum_c[WIDTH-1:0];
        c_c   = sum_c[WIDTH];
        v_c   = (bus.a[WIDTH-1] == b_eff[WIDTH-1]) &
                (sum_c[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_AND: res_c = bus.a & bus.b;
      OP_OR:  res_c = bus.a | bus.b;
      OP_XOR: res_c = bus.a ^ bus.b;
      OP_SHL: begin
        res_c = {bus.a[WIDTH-2:0], 1'b0};
        c_c   = bus.a[WIDTH-1];
      end
      OP_SHR: begin
        res_c = {1'b0, bus.a[WIDTH-1:1]};
        c_c   = bus.a[0];
      end
      default: begin
        // MUL: result comes from the multiplier (or is 0 when it is absent).
        res_c = '0;
      end
    endcase
    flg_c = pack_flags(res_c, c_c, v_c);
  end

`ifdef ALU_MUL_EN
  localparam int               CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t             state_p1;
  logic               rdy_p1;
  logic [CNT_W-1:0]   cnt_p1;
  logic               fwe_p1;
  logic [2*WIDTH-1:0] mcand_p1;
  logic [2*WIDTH-1:0] acc_p1;
  logic [WIDTH-1:0]   mplier_p1;
  logic [2*WIDTH-1:0] prod_c;

  assign xfer   = bus.in_valid & rdy_p1;
  // Accumulator value after this cycle's iteration; on the last iteration it
  // is the full 2*WIDTH-bit product.
  assign prod_c = acc_p1 + (mplier_p1[0] ? mcand_p1 : '0);

  // Stage p1: multiplier datapath. Loaded on a MUL transfer, then one
  // shift-add per BUSY cycle (LSB-first multiplier, left-shifting multiplicand).
  always_ff @(posedge clk) begin
    if (xfer && (bus.op == OP_MUL)) begin
      mcand_p1  <= {{WIDTH{1'b0}}, bus.a};
      mplier_p1 <= bus.b;
      acc_p1    <= '0;
      fwe_p1    <= bus.flags_we;
    end else if (state_p1 == BUSY) begin
      mcand_p1  <= mcand_p1 << 1;
      mplier_p1 <= mplier_p1 >> 1;
      acc_p1    <= prod_c;
    end
  end

  // Stage p1: control FSM, result and flags registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_p1 <= IDLE;
      rdy_p1   <= 1'b1;
      cnt_p1   <= '0;
      vld_p1   <= 1'b0;
      res_p1   <= '0;
      flg_p1   <= '0;
    end else begin
      vld_p1 <= 1'b0;
      case (state_p1)
        IDLE: begin
          if (xfer) begin
            if (bus.op == OP_MUL) begin
              state_p1 <= BUSY;
              rdy_p1   <= 1'b0;
              cnt_p1   <= '0;
            end else begin
              res_p1 <= res_c;
              vld_p1 <= 1'b1;
              if (bus.flags_we) flg_p1 <= flg_c;
            end
          end
        end
        BUSY: begin
          cnt_p1 <= cnt_p1 + 1'b1;
          if (cnt_p1 == CNT_LAST) begin
            // Completion and re-opening of the input share the same cycle.
            state_p1 <= IDLE;
            rdy_p1   <= 1'b1;
            vld_p1   <= 1'b1;
            res_p1   <= prod_c[WIDTH-1:0];
            if (fwe_p1)
              flg_p1 <= pack_flags(prod_c[WIDTH-1:0],
                                   |prod_c[2*WIDTH-1:WIDTH], 1'b0);
          end
        end
      endcase
    end
  end

  assign bus.in_ready = rdy_p1;
`else
  assign xfer = bus.in_valid;

  // Stage p1: result and flags registers; op 111 is a one-cycle no-op that
  // reports result 0 and leaves the flags alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
      res_p1 <= '0;
      flg_p1 <= '0;
    end else begin
      vld_p1 <= 1'b0;
      if (xfer) begin
        res_p1 <= res_c;
        vld_p1 <= 1'b1;
        if (bus.flags_we && (bus.op != OP_MUL)) flg_p1 <= flg_c;
      end
    end
  end

  assign bus.in_ready = 1'b1;
`endif

  assign bus.result    = res_p1;
  assign bus.out_valid = vld_p1;
  assign bus.flags     = flg_p1;

endmodule

// File: tb/tb_alu_seq.sv
// ---------------------------------------------------------------------------
// tb_alu_seq
// Directed bench for alu_seq at WIDTH=8. Expected results and {Z,C,N,V}
// flags are hand-computed constants. Multiply scenarios follow ALU_MUL_EN.
// ---------------------------------------------------------------------------
module tb_alu_seq;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  alu_if #(.WIDTH(8)) bus ();

  alu_seq #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Back-to-back logic/shift vectors and their expected outputs.
  logic [2:0] bb_op  [5] = '{OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR};
  logic [7:0] bb_a   [5] = '{8'hF0, 8'h0F, 8'hFF, 8'h81, 8'h02};
  logic [7:0] bb_b   [5] = '{8'h3C, 8'h80, 8'hFF, 8'h00, 8'h00};
  logic [7:0] bb_res [5] = '{8'h30, 8'h8F, 8'h00, 8'h02, 8'h01};
  logic [3:0] bb_flg [5] = '{4'b0000, 4'b0010, 4'b1000, 4'b0100, 4'b0000};

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one transfer for a single cycle; returns #1 after the capturing edge.
  task automatic issue(input logic [2:0] o, input logic [7:0] aa, input logic [7:0] bb,
                       input logic ce, input logic fw);
    bus.in_valid = 1'b1;
    bus.op       = o;
    bus.a        = aa;
    bus.b        = bb;
    bus.cin_en   = ce;
    bus.flags_we = fw;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic expect_out(input string tag, input logic [7:0] res, input logic [3:0] flg);
    chk({tag, "_vld"}, 16'(bus.out_valid), 16'(1'b1));
    chk({tag, "_res"}, 16'(bus.result), 16'(res));
    chk({tag, "_flg"}, 16'(bus.flags), 16'(flg));
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.op       = OP_ADD;
    bus.a        = '0;
    bus.b        = '0;
    bus.cin_en   = 1'b0;
    bus.flags_we = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_res", 16'(bus.result), 16'h0);
    chk("rst_flg", 16'(bus.flags), 16'h0);
    chk("rst_vld", 16'(bus.out_valid), 16'h0);
    chk("rst_rdy", 16'(bus.in_ready), 16'h1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Signed overflow on add.
    issue(OP_ADD, 8'h7F, 8'h01, 1'b0, 1'b1);
    expect_out("add_ovf", 8'h80, 4'b0011);
    @(posedge clk);
    #1;
    chk("vld_pulse", 16'(bus.out_valid), 16'h0);

    issue(OP_SUB, 8'h05, 8'h05, 1'b0, 1'b1);
    expect_out("sub_eq", 8'h00, 4'b1100);
    issue(OP_SUB, 8'h03, 8'h05, 1'b0, 1'b1);
    expect_out("sub_borrow", 8'hFE, 4'b0010);

    // Carry chaining: the stored C=1 feeds the next add.
    issue(OP_ADD, 8'hFF, 8'h01, 1'b0, 1'b1);
    expect_out("add_wrap", 8'h00, 4'b1100);
    issue(OP_ADD, 8'h00, 8'h00, 1'b1, 1'b1);
    expect_out("adc", 8'h01, 4'b0000);
    issue(OP_ADD, 8'h80, 8'h80, 1'b0, 1'b0);
    expect_out("add_nofw", 8'h00, 4'b0000);

    // Borrow-chained subtract: C=0 from here makes 0x05-0x03-1.
    issue(OP_SUB, 8'h03, 8'h05, 1'b0, 1'b1);
    issue(OP_SUB, 8'h05, 8'h03, 1'b1, 1'b1);
    expect_out("sbc", 8'h01, 4'b0100);

    // Set C so the first logic op visibly clears it, then stream 5 ops.
    issue(OP_ADD, 8'hFF, 8'h01, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1;
      bus.op       = bb_op[i];
      bus.a        = bb_a[i];
      bus.b        = bb_b[i];
      bus.cin_en   = 1'b0;
      bus.flags_we = 1'b1;
      chk($sformatf("b2b_rdy%0d", i), 16'(bus.in_ready), 16'h1);
      @(posedge clk);
      #1;
      expect_out($sformatf("b2b%0d", i), bb_res[i], bb_flg[i]);
    end
    bus.in_valid = 1'b0;

`ifdef ALU_MUL_EN
    issue(OP_MUL, 8'h0F, 8'h11, 1'b0, 1'b1);
    // Offer an ADD throughout BUSY; it must only be taken once ready returns.
    bus.in_valid = 1'b1;
    bus.op       = OP_ADD;
    bus.a        = 8'h01;
    bus.b        = 8'h01;
    bus.cin_en   = 1'b0;
    bus.flags_we = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      chk($sformatf("mul_busy_rdy%0d", k), 16'(bus.in_ready), 16'h0);
      chk($sformatf("mul_busy_vld%0d", k), 16'(bus.out_valid), 16'h0);
      @(posedge clk);
      #1;
    end
    expect_out("mul_0f11", 8'hFF, 4'b0010);
    chk("mul_done_rdy", 16'(bus.in_ready), 16'h1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    expect_out("add_after_mul", 8'h02, 4'b0000);

    issue(OP_MUL, 8'h10, 8'h10, 1'b0, 1'b1);
    repeat (8) @(posedge clk);
    #1;
    expect_out("mul_1010", 8'h00, 4'b1100);

    // Abort a multiply in flight with reset.
    issue(OP_ADD, 8'h7F, 8'h01, 1'b0, 1'b1);
    issue(OP_MUL, 8'h0F, 8'h11, 1'b0, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_res", 16'(bus.result), 16'h0);
    chk("abort_flg", 16'(bus.flags), 16'h0);
    chk("abort_vld", 16'(bus.out_valid), 16'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("abort_rdy", 16'(bus.in_ready), 16'h1);
    repeat (10) begin
      @(posedge clk);
      #1;
      checks++;
      assert (bus.out_valid === 1'b0) else begin
        errors++;
        $error("FAIL abort_stale_vld observed=%h expected=0", bus.out_valid);
      end
    end
    issue(OP_ADD, 8'h7F, 8'h01, 1'b0, 1'b1);
    expect_out("add_post_rst", 8'h80, 4'b0011);
`else
    issue(OP_ADD, 8'h7F, 8'h01, 1'b0, 1'b1);
    issue(OP_MUL, 8'h0F, 8'h11, 1'b0, 1'b1);
    expect_out("mul_off", 8'h00, 4'b0011);
    chk("mul_off_rdy", 16'(bus.in_ready), 16'h1);

    rst_n = 1'b0;
    #1;
    chk("arst_res", 16'(bus.result), 16'h0);
    chk("arst_flg", 16'(bus.flags), 16'h0);
    chk("arst_vld", 16'(bus.out_valid), 16'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("arst_rdy", 16'(bus.in_ready), 16'h1);
    issue(OP_ADD, 8'h7F, 8'h01, 1'b0, 1'b1);
    expect_out("add_post_rst", 8'h80, 4'b0011);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
